hid_report_to_xt: RTL

Converts the HID boot-keyboard reports from the USB low-speed HID host into an XT/AT scan-code-set-1 byte stream. Each new report is diffed against the previous one, producing make/break codes (with E0 prefixes where needed), and the bytes are buffered in a 16-entry FIFO. The block sits between the USB HID host and the keyboard-controller (port 60h/IRQ1) emulation in the 286 system.

---
 rtl/xt_kbd_pkg.sv | 63 ++++++
 rtl/hid_report_to_xt_if.sv | 14 +
 rtl/hid_usage_to_set1.sv | 46 ++++
 rtl/hid_report_to_xt.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xt_kbd_pkg.sv
// Shared definitions for the HID-report to XT scan-code-set-1 converter.
// Holds the diff-engine state encoding, the fixed byte constants, the
// modifier-bit code table and small helpers over the three key slots.
package xt_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SNAP = 3'd1,
        ST_MOD  = 3'd2,
        ST_BRK  = 3'd3,
        ST_MAK  = 3'd4,
        ST_PFX  = 3'd5
    } xt_state_e;

    // Slot 0 holds keycode1, slot 2 holds keycode3.
    typedef logic [2:0][7:0] key_slots_t;

    localparam logic [7:0] E0_PREFIX    = 8'hE0;
    localparam logic [7:0] BREAK_BIT    = 8'h80;
    localparam logic [7:0] HID_ROLLOVER = 8'h01;

    // Modifier bit -> {ext, code[6:0]}; bit 7 of the result marks an E0 code.
    function automatic logic [7:0] mod_code(input logic [2:0] bit_idx);
        case (bit_idx)
            3'd0:    mod_code = 8'h1D;  // LCtrl
            3'd1:    mod_code = 8'h2A;  // LShift
            3'd2:    mod_code = 8'h38;  // LAlt
            3'd3:    mod_code = 8'hDB;  // LGUI   E0 5B
            3'd4:    mod_code = 8'h9D;  // RCtrl  E0 1D
            3'd5:    mod_code = 8'h36;  // RShift
            3'd6:    mod_code = 8'hB8;  // RAlt   E0 38
            default: mod_code = 8'hDC;  // RGUI   E0 5C
        endcase
    endfunction

    // Final byte written to the FIFO: 7-bit code with the break bit or'ed in.
    function automatic logic [7:0] set1_byte(input logic [6:0] code, input logic brk);
        set1_byte = {1'b0, code} | (brk ? BREAK_BIT : 8'h00);
    endfunction

    function automatic logic [7:0] slot_of(input key_slots_t keys, input logic [1:0] sel);
        case (sel)
            2'd0:    slot_of = keys[0];
            2'd1:    slot_of = keys[1];
            default: slot_of = keys[2];
        endcase
    endfunction

    function automatic logic in_slots(input logic [7:0] usage, input key_slots_t keys);
        in_slots = (usage == keys[0]) || (usage == keys[1]) || (usage == keys[2]);
    endfunction

    // True when the usage in slot 'sel' already appeared in a lower slot, so a
    // duplicated usage inside one report is only ever reported once.
    function automatic logic dup_before(input key_slots_t keys, input logic [1:0] sel);
        case (sel)
            2'd1:    dup_before = (keys[1] == keys[0]);
            2'd2:    dup_before = (keys[2] == keys[0]) || (keys[2] == keys[1]);
            default: dup_before = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hid_report_to_xt_if.sv
// Scan-code byte stream between the converter and the keyboard-controller
// emulation.
//   scancode        FIFO head byte, valid while scancode_avail is high
//   scancode_avail  FIFO non-empty (IRQ1 request level)
//   scancode_rd     one-cycle pop strobe from the consumer
// master = converter (producer), slave = keyboard-controller side.
interface hid_report_to_xt_if;
    logic [7:0] scancode;
    logic       scancode_avail;
    logic       scancode_rd;

    modport master (output scancode, output scancode_avail, input scancode_rd);
    modport slave  (input scancode, input scancode_avail, output scancode_rd);
endinterface

// File: rtl/hid_usage_to_set1.sv
// Combinational ROM: HID keyboard usage -> scan-code set 1.
//   usage  in   HID usage code
//   entry  out  {ext, code[6:0]}; ext=1 means the code needs an E0 prefix,
//               8'h00 means the usage has no translation.
module hid_usage_to_set1 (
    input  logic [7:0] usage,
    output logic [7:0] entry
);

    // Usage lookup table; anything outside 04..65 has no translation.
    always_comb begin
        case (usage)
            8'h04: entry = 8'h1E;  8'h05: entry = 8'h30;  8'h06: entry = 8'h2E;  8'h07: entry = 8'h20;
            8'h08: entry = 8'h12;  8'h09: entry = 8'h21;  8'h0A: entry = 8'h22;  8'h0B: entry = 8'h23;
            8'h0C: entry = 8'h17;  8'h0D: entry = 8'h24;  8'h0E: entry = 8'h25;  8'h0F: entry = 8'h26;
            8'h10: entry = 8'h32;  8'h11: entry = 8'h31;  8'h12: entry = 8'h18;  8'h13: entry = 8'h19;
            8'h14: entry = 8'h10;  8'h15: entry = 8'h13;  8'h16: entry = 8'h1F;  8'h17: entry = 8'h14;
            8'h18: entry = 8'h16;  8'h19: entry = 8'h2F;  8'h1A: entry = 8'h11;  8'h1B: entry = 8'h2D;
            8'h1C: entry = 8'h15;  8'h1D: entry = 8'h2C;
            8'h1E: entry = 8'h02;  8'h1F: entry = 8'h03;  8'h20: entry = 8'h04;  8'h21: entry = 8'h05;
            8'h22: entry = 8'h06;  8'h23: entry = 8'h07;  8'h24: entry = 8'h08;  8'h25: entry = 8'h09;
            8'h26: entry = 8'h0A;  8'h27: entry = 8'h0B;
            8'h28: entry = 8'h1C;  8'h29: entry = 8'h01;  8'h2A: entry = 8'h0E;  8'h2B: entry = 8'h0F;
            8'h2C: entry = 8'h39;  8'h2D: entry = 8'h0C;  8'h2E: entry = 8'h0D;  8'h2F: entry = 8'h1A;
            8'h30: entry = 8'h1B;  8'h31: entry = 8'h2B;  8'h32: entry = 8'h2B;  8'h33: entry = 8'h27;
            8'h34: entry = 8'h28;  8'h35: entry = 8'h29;  8'h36: entry = 8'h33;  8'h37: entry = 8'h34;
            8'h38: entry = 8'h35;  8'h39: entry = 8'h3A;
            8'h3A: entry = 8'h3B;  8'h3B: entry = 8'h3C;  8'h3C: entry = 8'h3D;  8'h3D: entry = 8'h3E;
            8'h3E: entry = 8'h3F;  8'h3F: entry = 8'h40;  8'h40: entry = 8'h41;  8'h41: entry = 8'h42;
            8'h42: entry = 8'h43;  8'h43: entry = 8'h44;  8'h44: entry = 8'h57;  8'h45: entry = 8'h58;
            8'h46: entry = 8'hB7;  // PrintScr   E0 37
            8'h47: entry = 8'h46;  // ScrollLock
            8'h48: entry = 8'hC6;  // Pause: real set-1 Pause is an E1 sequence; the E0 46 (Ctrl-Break) form is used
            8'h49: entry = 8'hD2;  8'h4A: entry = 8'hC7;  8'h4B: entry = 8'hC9;  8'h4C: entry = 8'hD3;
            8'h4D: entry = 8'hCF;  8'h4E: entry = 8'hD1;
            8'h4F: entry = 8'hCD;  8'h50: entry = 8'hCB;  8'h51: entry = 8'hD0;  8'h52: entry = 8'hC8;
            8'h53: entry = 8'h45;  8'h54: entry = 8'hB5;  8'h55: entry = 8'h37;  8'h56: entry = 8'h4A;
            8'h57: entry = 8'h4E;  8'h58: entry = 8'h9C;  8'h59: entry = 8'h4F;  8'h5A: entry = 8'h50;
            8'h5B: entry = 8'h51;  8'h5C: entry = 8'h4B;  8'h5D: entry = 8'h4C;  8'h5E: entry = 8'h4D;
            8'h5F: entry = 8'h47;  8'h60: entry = 8'h48;  8'h61: entry = 8'h49;  8'h62: entry = 8'h52;
            8'h63: entry = 8'h53;  8'h64: entry = 8'h56;  8'h65: entry = 8'hDD;
            default: entry = 8'h00;
        endcase
    end

endmodule

// File: rtl/hid_report_to_xt.sv
// HID boot-keyboard report -> XT scan-code-set-1 byte stream.
// Each new report (report_flip toggle) is diffed against the previous one:
// modifier bits first, then released keys, then pressed keys. Resulting
// bytes go into a DEPTH-entry FIFO read by the keyboard-controller model.
//   clk, reset        clock, synchronous active-high reset
//   shift             HID modifier byte (bit0 LCtrl .. bit7 RGUI)
//   keycode1..3       HID usages of the report, 00 = empty slot
//   report_flip       toggles once per new report
//   busy              diff engine not idle
//   sc                scan-code byte stream (master side)
module hid_report_to_xt
    import xt_kbd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                shift,
    input  logic [7:0]                keycode1,
    input  logic [7:0]                keycode2,
    input  logic [7:0]                keycode3,
    input  logic                      report_flip,
    output logic                      busy,
    hid_report_to_xt_if.master        sc
);

    localparam int AW = $clog2(DEPTH);

    xt_state_e      state_r, state_s, ret_state_r, adv_state_s, adv_base_s;
    logic [2:0]     idx_r, idx_s, adv_idx_s;
    logic           adv_commit_s, commit_s;
    logic           flip_seen_r, pending_r, clr_pending_s;
    logic           snap_s, rollover_s, go_pfx_s;
    logic [7:0]     new_shift_r, prev_shift_r;
    key_slots_t     new_key_r, prev_key_r;
    logic [7:0]     pfx_byte_r;
    logic [7:0]     step_usage_s, step_entry_s, rom_entry_s;
    logic           step_emit_s, step_brk_s;
    logic           wr_en_s;
    logic [7:0]     wr_data_s;

    logic [7:0]     mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
    logic           full_s, pop_s;
    logic [7:0]     head_nx_s, scancode_r;
    logic           avail_r, busy_r;

    hid_usage_to_set1 u_rom (
        .usage (step_usage_s),
        .entry (rom_entry_s)
    );

    assign rollover_s = (keycode1 == HID_ROLLOVER) || (keycode2 == HID_ROLLOVER) ||
                        (keycode3 == HID_ROLLOVER);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s      = sc.scancode_rd && avail_r;

    assign sc.scancode       = scancode_r;
    assign sc.scancode_avail = avail_r;
    assign busy              = busy_r;

    // Decide what the current diff step would emit (code, make/break, whether at all).
    always_comb begin
        step_usage_s = (state_r == ST_BRK) ? slot_of(prev_key_r, idx_r[1:0])
                                           : slot_of(new_key_r, idx_r[1:0]);
        step_entry_s = 8'h00;
        step_emit_s  = 1'b0;
        step_brk_s   = 1'b0;
        case (state_r)
            ST_MOD: begin
                step_entry_s = mod_code(idx_r);
                step_emit_s  = new_shift_r[idx_r] ^ prev_shift_r[idx_r];
                step_brk_s   = prev_shift_r[idx_r];
            end
            ST_BRK: begin
                step_entry_s = rom_entry_s;
                step_emit_s  = (step_usage_s != 8'h00) && !in_slots(step_usage_s, new_key_r) &&
                               !dup_before(prev_key_r, idx_r[1:0]) && (rom_entry_s != 8'h00);
                step_brk_s   = 1'b1;
            end
            ST_MAK: begin
                step_entry_s = rom_entry_s;
                step_emit_s  = (step_usage_s != 8'h00) && !in_slots(step_usage_s, prev_key_r) &&
                               !dup_before(new_key_r, idx_r[1:0]) && (rom_entry_s != 8'h00);
                step_brk_s   = 1'b0;
            end
            default: begin
                step_entry_s = 8'h00;
            end
        endcase
    end

    // Where the walk goes after the current index is finished; PFX finishes the caller's index.
    always_comb begin
        adv_base_s   = (state_r == ST_PFX) ? ret_state_r : state_r;
        adv_state_s  = ST_IDLE;
        adv_idx_s    = 3'd0;
        adv_commit_s = 1'b0;
        case (adv_base_s)
            ST_MOD: begin
                if (idx_r == 3'd7) begin
                    adv_state_s = ST_BRK;
                end else begin
                    adv_state_s = ST_MOD;
                    adv_idx_s   = idx_r + 3'd1;
                end
            end
            ST_BRK: begin
                if (idx_r == 3'd2) begin
                    adv_state_s = ST_MAK;
                end else begin
                    adv_state_s = ST_BRK;
                    adv_idx_s   = idx_r + 3'd1;
                end
            end
            ST_MAK: begin
                if (idx_r == 3'd2) begin
                    adv_state_s  = ST_IDLE;
                    adv_commit_s = 1'b1;
                end else begin
                    adv_state_s = ST_MAK;
                    adv_idx_s   = idx_r + 3'd1;
                end
            end
            default: begin
                adv_state_s = ST_IDLE;
            end
        endcase
    end

    // Next-state and FIFO-write decode; a needed write into a full FIFO freezes the walk.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        commit_s      = 1'b0;
        clr_pending_s = 1'b0;
        snap_s        = 1'b0;
        go_pfx_s      = 1'b0;
        wr_en_s       = 1'b0;
        wr_data_s     = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    state_s       = ST_SNAP;
                    clr_pending_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SNAP: begin
                snap_s = 1'b1;
                idx_s  = 3'd0;
                if (rollover_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MOD;
                end
            end
            ST_MOD, ST_BRK, ST_MAK: begin
                // Extended codes write E0 here and the code byte itself from PFX.
                wr_data_s = step_entry_s[7] ? E0_PREFIX : set1_byte(step_entry_s[6:0], step_brk_s);
                if (!step_emit_s) begin
                    state_s  = adv_state_s;
                    idx_s    = adv_idx_s;
                    commit_s = adv_commit_s;
                end else if (full_s) begin
                    state_s = state_r;
                end else if (step_entry_s[7]) begin
                    wr_en_s  = 1'b1;
                    go_pfx_s = 1'b1;
                    state_s  = ST_PFX;
                end else begin
                    wr_en_s  = 1'b1;
                    state_s  = adv_state_s;
                    idx_s    = adv_idx_s;
                    commit_s = adv_commit_s;
                end
            end
            ST_PFX: begin
                wr_data_s = pfx_byte_r;
                if (full_s) begin
                    state_s = ST_PFX;
                end else begin
                    wr_en_s  = 1'b1;
                    state_s  = adv_state_s;
                    idx_s    = adv_idx_s;
                    commit_s = adv_commit_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer advance and the head byte that will be visible next cycle.
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
        rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        if (rd_ptr_nx_s == wr_ptr_nx_s) begin
            head_nx_s = 8'h00;
        end else if (wr_en_s && (rd_ptr_nx_s == wr_ptr_r)) begin
            head_nx_s = wr_data_s;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s[AW-1:0]];
        end
    end

    // FSM, report snapshots, toggle detection, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ret_state_r  <= ST_IDLE;
            idx_r        <= 3'd0;
            flip_seen_r  <= report_flip;
            pending_r    <= 1'b0;
            new_shift_r  <= 8'h00;
            new_key_r    <= '0;
            prev_shift_r <= 8'h00;
            prev_key_r   <= '0;
            pfx_byte_r   <= 8'h00;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            scancode_r   <= 8'h00;
            avail_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            flip_seen_r <= report_flip;
            // A fresh toggle wins over the IDLE->SNAP clear so no report is lost.
            if (flip_seen_r != report_flip) begin
                pending_r <= 1'b1;
            end else if (clr_pending_s) begin
                pending_r <= 1'b0;
            end
            if (snap_s && !rollover_s) begin
                new_shift_r <= shift;
                new_key_r   <= {keycode3, keycode2, keycode1};
            end
            if (go_pfx_s) begin
                ret_state_r <= state_r;
                pfx_byte_r  <= set1_byte(step_entry_s[6:0], step_brk_s);
            end
            if (commit_s) begin
                prev_shift_r <= new_shift_r;
                prev_key_r   <= new_key_r;
            end
            wr_ptr_r   <= wr_ptr_nx_s;
            rd_ptr_r   <= rd_ptr_nx_s;
            scancode_r <= head_nx_s;
            avail_r    <= (rd_ptr_nx_s != wr_ptr_nx_s);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
        end
    end

endmodule
